frequency_meter: RTL and testbench

Measures the frequency and period of an asynchronous square-wave input against the system clock. It is the inverse of the clock divider: the divider turns a `speed` value into a clock, and this block turns a clock-like signal back into a `speed`-compatible count and a period in `clk` cycles. It sits beside the divider so benches and on-board debug can read back generated rates, and it also measures external pulse trains.

---
 rtl/frequency_meter.sv | 151 +++++++++++++++
 tb/tb_frequency_meter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/frequency_meter.sv
`default_nettype none
// ============================================================================
//  Module      : frequency_meter
//  Description : Measures the frequency (rising edges per gate window of
//                BASE_SPEED clk cycles, i.e. Hz) and the period (clk cycles
//                between consecutive rising edges) of an asynchronous
//                square-wave input.
//  Ports       :
//    clk          in   system clock
//    reset        in   synchronous active-high reset (hold >= 3 cycles)
//    sigIn        in   measured signal, asynchronous to clk
//    freq         out  rising edges counted in the last complete window
//    freqValid    out  one-cycle pulse when freq/overflow update
//    overflow     out  last window's edge count saturated
//    period       out  clk cycles between the last two edges, 0 on timeout
//    periodValid  out  one-cycle pulse when period updates
//  Revision    : 1.0  initial release
// ============================================================================
module frequency_meter #(
    parameter int BASE_SPEED = 50000000,
    parameter int COUNT_W    = 20,
    parameter int PW         = $clog2(BASE_SPEED + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sigIn,
    output logic [COUNT_W-1:0] freq,
    output logic               freqValid,
    output logic               overflow,
    output logic [PW-1:0]      period,
    output logic               periodValid
);

    localparam logic [PW-1:0]      C_WIN_LAST = PW'(BASE_SPEED - 1);
    localparam logic [PW-1:0]      C_PER_MAX  = PW'(BASE_SPEED);
    localparam logic [COUNT_W-1:0] C_CNT_MAX  = '1;

    typedef enum logic [0:0] {
        ST_ARM     = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Synchronizer. No reset: the chain keeps following sigIn during reset so
    // that a steady high level at reset release does not look like an edge.
    // ------------------------------------------------------------------------
    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic w_edge;

    always_ff @(posedge clk) begin
        r_s1 <= sigIn;
        r_s2 <= r_s1;
        r_s3 <= r_s2;
    end

    assign w_edge = r_s2 & ~r_s3;

    // ------------------------------------------------------------------------
    // Gate window: count edges over BASE_SPEED cycles. The edge seen in the
    // last cycle of a window still belongs to that window, so it is folded
    // into the published count directly rather than into r_edge_cnt.
    // ------------------------------------------------------------------------
    logic [PW-1:0]      r_win_cnt;
    logic [COUNT_W-1:0] r_edge_cnt;
    logic               r_sat;
    logic               w_win_end;

    assign w_win_end = (r_win_cnt == C_WIN_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            freq       <= '0;
            freqValid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            freqValid <= 1'b0;
            if (w_win_end) begin
                r_win_cnt  <= '0;
                r_edge_cnt <= '0;
                r_sat      <= 1'b0;
                freqValid  <= 1'b1;
                if (w_edge && (r_edge_cnt == C_CNT_MAX)) begin
                    freq     <= C_CNT_MAX;
                    overflow <= 1'b1;
                end else begin
                    freq     <= r_edge_cnt + {{(COUNT_W-1){1'b0}}, w_edge};
                    overflow <= r_sat;
                end
            end else begin
                r_win_cnt <= r_win_cnt + 1'b1;
                if (w_edge) begin
                    if (r_edge_cnt == C_CNT_MAX) begin
                        r_sat <= 1'b1;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Period FSM. r_per_cnt holds the number of cycles since the last edge
    // (1 in the cycle right after it). An edge at r_per_cnt == BASE_SPEED wins
    // over the timeout so a period of exactly BASE_SPEED can be reported.
    // ------------------------------------------------------------------------
    state_t        r_state;
    logic [PW-1:0] r_per_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_ARM;
            r_per_cnt   <= '0;
            period      <= '0;
            periodValid <= 1'b0;
        end else begin
            periodValid <= 1'b0;
            case (r_state)
                ST_ARM: begin
                    if (w_edge) begin
                        r_state   <= ST_MEASURE;
                        r_per_cnt <= PW'(1);
                    end
                end
                ST_MEASURE: begin
                    if (w_edge) begin
                        period      <= r_per_cnt;
                        periodValid <= 1'b1;
                        r_per_cnt   <= PW'(1);
                    end else if (r_per_cnt == C_PER_MAX) begin
                        period      <= '0;
                        periodValid <= 1'b1;
                        r_state     <= ST_ARM;
                    end else begin
                        r_per_cnt <= r_per_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_ARM;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frequency_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frequency_meter
//  Description : Self-checking bench for frequency_meter. Two instances share
//                stimulus: a wide counter (COUNT_W=20) and a narrow one
//                (COUNT_W=4) that saturates. A timestamp-based reference
//                model predicts every output on every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frequency_meter;

    localparam int BASE  = 1000;
    localparam int PWT   = $clog2(BASE + 1);
    localparam int MAX_W = (1 << 20) - 1;
    localparam int MAX_N = (1 << 4) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            sigIn = 1'b0;

    logic [19:0]     freq_w;
    logic            fv_w;
    logic            ovf_w;
    logic [PWT-1:0]  per_w;
    logic            pv_w;

    logic [3:0]      freq_n;
    logic            fv_n;
    logic            ovf_n;
    logic [PWT-1:0]  per_n;
    logic            pv_n;

    frequency_meter #(.BASE_SPEED(BASE), .COUNT_W(20)) u_dut_w (
        .clk(clk), .reset(reset), .sigIn(sigIn),
        .freq(freq_w), .freqValid(fv_w), .overflow(ovf_w),
        .period(per_w), .periodValid(pv_w)
    );

    frequency_meter #(.BASE_SPEED(BASE), .COUNT_W(4)) u_dut_n (
        .clk(clk), .reset(reset), .sigIn(sigIn),
        .freq(freq_n), .freqValid(fv_n), .overflow(ovf_n),
        .period(per_n), .periodValid(pv_n)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int cyc = 0;           // posedge index
    int m_pos = 0;         // position inside the current window
    int m_cnt = 0;         // unbounded edge count of the current window
    bit m_armed = 1'b0;    // a previous edge time is known
    int m_last = 0;        // posedge index at which the previous edge counted
    bit h1 = 1'b0, h2 = 1'b0, h3 = 1'b0; // sigIn sampled 1, 2, 3 edges ago
    int e_freq_w = 0, e_freq_n = 0, e_period = 0;
    bit e_fv = 1'b0, e_ovf_w = 1'b0, e_ovf_n = 1'b0, e_pv = 1'b0;
    int ph = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // A rising level sampled at posedge k is counted at posedge k+2; the
    // period is the distance between those counting instants.
    task automatic model(input bit v, input bit r);
        bit e;
        cyc++;
        if (r) begin
            m_pos = 0; m_cnt = 0; m_armed = 1'b0;
            e_fv = 1'b0; e_pv = 1'b0; e_period = 0;
            e_freq_w = 0; e_freq_n = 0; e_ovf_w = 1'b0; e_ovf_n = 1'b0;
        end else begin
            e = h2 && !h3;
            if (e) m_cnt++;
            e_fv = 1'b0;
            if (m_pos == BASE - 1) begin
                e_fv     = 1'b1;
                e_freq_w = (m_cnt > MAX_W) ? MAX_W : m_cnt;
                e_ovf_w  = (m_cnt > MAX_W);
                e_freq_n = (m_cnt > MAX_N) ? MAX_N : m_cnt;
                e_ovf_n  = (m_cnt > MAX_N);
                m_cnt = 0;
                m_pos = 0;
            end else begin
                m_pos++;
            end
            e_pv = 1'b0;
            if (e) begin
                if (m_armed) begin
                    e_pv = 1'b1;
                    e_period = cyc - m_last;
                end
                m_armed = 1'b1;
                m_last  = cyc;
            end else if (m_armed && (cyc - m_last == BASE)) begin
                e_pv = 1'b1;
                e_period = 0;
                m_armed = 1'b0;
            end
        end
        h3 = h2; h2 = h1; h1 = v;
    endtask

    task automatic step(input bit s, input bit r);
        sigIn = s;
        reset = r;
        @(posedge clk);
        #1;
        model(s, r);
        check("freqValid_w", 64'(fv_w), 64'(e_fv));
        check("freqValid_n", 64'(fv_n), 64'(e_fv));
        check("freq_w", 64'(freq_w), 64'(e_freq_w));
        check("freq_n", 64'(freq_n), 64'(e_freq_n));
        check("overflow_w", 64'(ovf_w), 64'(e_ovf_w));
        check("overflow_n", 64'(ovf_n), 64'(e_ovf_n));
        check("periodValid_w", 64'(pv_w), 64'(e_pv));
        check("periodValid_n", 64'(pv_n), 64'(e_pv));
        check("period_w", 64'(per_w), 64'(e_period));
        check("period_n", 64'(per_n), 64'(e_period));
    endtask

    task automatic square(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            if (ph >= per) ph = 0;
            step(ph < hi, 1'b0);
            ph++;
        end
    endtask

    task automatic hold(input bit s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b0);
    endtask

    task automatic do_reset(input bit s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b1);
    endtask

    initial begin
        do_reset(1'b0, 5);
        square(10, 5, 2100);
        square(4, 2, 1500);
        square(7, 3, 1500);
        hold(1'b0, 1200);
        hold(1'b1, 1200);
        hold(1'b0, 20);
        hold(1'b1, 3);
        hold(1'b0, 1100);
        square(2, 1, 1500);
        square(100, 50, 2200);
        square(1000, 500, 3000);
        // Reset in the middle of a window with sigIn high throughout.
        for (int i = 0; i < 2000 && m_pos != 500; i++) square(10, 5, 1);
        do_reset(1'b1, 3);
        hold(1'b1, 20);
        square(10, 5, 2100);
        for (int k = 0; k < 8; k++) begin
            int p;
            p = $urandom_range(80, 2);
            square(p, $urandom_range(p - 1, 1), $urandom_range(1500, 300));
            if ($urandom_range(3, 0) == 0) do_reset(sigIn, $urandom_range(5, 3));
        end
        for (int i = 0; i < 1000; i++) step(1'($urandom), 1'b0);
        hold(1'b0, 1100);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
